// File: rtl/uart_tx_seq.sv
// uart_tx_seq: 8N1 UART transmitter whose data bits come from an external 4-bit shift register
module uart_tx_seq #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       sr_q0,
  output logic [1:0] sr_mode,
  output logic [3:0] sr_d,
  output logic       sr_in_rs,
  output logic       sr_in_ls,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);
  localparam logic [1:0]  SR_HOLD   = 2'b00;
  localparam logic [1:0]  SR_SHR    = 2'b01;
  localparam logic [1:0]  SR_LOAD   = 2'b11;
  state_t      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  sr_mode_q, sr_mode_d;
  logic [3:0]  sr_d_q, sr_d_d;
  logic        bit_last, bit_pre;
  logic [15:0] baud_next;
  assign bit_last  = baud_cnt_q == BAUD_LAST;
  assign bit_pre   = baud_cnt_q == BAUD_PRE;
  assign baud_next = bit_last ? 16'd0 : baud_cnt_q + 16'd1;
  assign sr_mode   = sr_mode_q;
  assign sr_d      = sr_d_q;
  assign sr_in_rs  = 1'b0;
  assign sr_in_ls  = 1'b0;
  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  // Next-state: sr_mode/sr_d are registered, so shift/load commands are issued one cycle ahead (bit_pre)
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sr_mode_d  = SR_HOLD;
    sr_d_d     = sr_d_q;
    case (state_q)
      IDLE: if (tx_start) begin
        state_d    = START;
        data_d     = tx_data;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
        baud_cnt_d = 16'd0;
        bit_idx_d  = 3'd0;
        sr_mode_d  = SR_LOAD;
        sr_d_d     = tx_data[3:0];
      end
      START: begin
        baud_cnt_d = baud_next;
        if (bit_last) begin
          state_d = DATA;
          tx_d    = sr_q0;
        end
      end
      DATA: begin
        baud_cnt_d = baud_next;
        if (bit_pre) begin
          sr_mode_d = bit_idx_q == 3'd3 ? SR_LOAD : bit_idx_q == 3'd7 ? SR_HOLD : SR_SHR;
          sr_d_d    = bit_idx_q == 3'd3 ? data_q[7:4] : sr_d_q;
        end
        if (bit_last) begin
          bit_idx_d = bit_idx_q + 3'd1;
          state_d   = bit_idx_q == 3'd7 ? STOP : DATA;
          tx_d      = bit_idx_q == 3'd7 ? 1'b1 : sr_q0;
        end
      end
      STOP: begin
        baud_cnt_d = baud_next;
        if (bit_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State register with synchronous active-low clear that aborts any frame
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sr_mode_q  <= SR_HOLD;
      sr_d_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sr_mode_q  <= sr_mode_d;
      sr_d_q     <= sr_d_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_seq.sv
// tb_uart_tx_seq: scoreboard bench for uart_tx_seq at CLKS_PER_BIT 4 and 2
module tb_uart_tx_seq;
  typedef struct {
    int         sel;
    logic [7:0] data;
    int         abort;
  } exp_t;
  logic       clk;
  logic       clr_a   [2];
  logic       start_a [2];
  logic [7:0] data_a  [2];
  logic       q0_a    [2];
  logic [1:0] mode_a  [2];
  logic [3:0] sd_a    [2];
  logic       rs_a    [2];
  logic       ls_a    [2];
  logic       tx_a    [2];
  logic       busy_a  [2];
  logic       done_a  [2];
  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  logic       mon_en = 1'b0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int N = (g == 0) ? 4 : 2;
    logic [3:0] sr = 4'd0;
    assign q0_a[g] = sr[0];
    uart_tx_seq #(.CLKS_PER_BIT(N)) dut (
      .clk(clk), .clear_n(clr_a[g]), .tx_start(start_a[g]), .tx_data(data_a[g]),
      .sr_q0(q0_a[g]), .sr_mode(mode_a[g]), .sr_d(sd_a[g]), .sr_in_rs(rs_a[g]),
      .sr_in_ls(ls_a[g]), .tx(tx_a[g]), .tx_busy(busy_a[g]), .tx_done(done_a[g])
    );
    always @(negedge clk)
      case (mode_a[g])
        2'b01:   sr <= {rs_a[g], sr[3:1]};
        2'b10:   sr <= {sr[2:0], ls_a[g]};
        2'b11:   sr <= sd_a[g];
        default: sr <= sr;
      endcase
    initial begin : mon
      exp_t e;
      int k;
      logic ev;
      logic [1:0] em;
      wait (mon_en);
      forever begin
        @(negedge clk);
        if (!busy_a[g]) begin
          chk($sformatf("idle u%0d", g), 16'({tx_a[g], done_a[g], mode_a[g], rs_a[g], ls_a[g]}), 16'b100000);
        end else begin
          chk($sformatf("frame_expected u%0d", g), 16'(sbq.size() != 0), 16'd1);
          e = '{sel: -1, data: 8'd0, abort: 0};
          if (sbq.size() != 0) e = sbq.pop_front();
          chk($sformatf("frame_inst u%0d", g), 16'(e.sel), 16'(g));
          for (int c = 1; c <= 10 * N + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (e.abort != 0 && c == e.abort + 1) begin
              chk($sformatf("abort u%0d c%0d", g, c), 16'({tx_a[g], busy_a[g], done_a[g], mode_a[g], sd_a[g]}), 16'b100_00_0000);
              break;
            end
            k  = (c - 1) / N;
            ev = (c > 10 * N || k == 9) ? 1'b1 : (k == 0) ? 1'b0 : e.data[k-1];
            em = (c == 1) ? 2'b11 : (k >= 1 && k <= 8 && c % N == 0) ? ((k == 4) ? 2'b11 : (k == 8) ? 2'b00 : 2'b01) : 2'b00;
            chk($sformatf("frame u%0d byte %h c%0d tx,busy,done,mode,rs,ls", g, e.data, c),
                16'({tx_a[g], busy_a[g], done_a[g], mode_a[g], rs_a[g], ls_a[g]}),
                16'({ev, 1'(c <= 10 * N), 1'(c == 10 * N + 1), em, 2'b00}));
            if (em == 2'b11)
              chk($sformatf("sr_d u%0d c%0d", g, c), 16'(sd_a[g]), 16'((c == 1) ? e.data[3:0] : e.data[7:4]));
          end
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int s, input logic [7:0] d, input int ab);
    exp_t e;
    e = '{sel: s, data: d, abort: ab};
    sbq.push_back(e);
    data_a[s]  = d;
    start_a[s] = 1'b1;
    step();
    start_a[s] = 1'b0;
    data_a[s]  = ~d;
  endtask
  initial begin
    exp_t e;
    clr_a   = '{1'b0, 1'b0};
    start_a = '{1'b0, 1'b0};
    data_a  = '{8'h00, 8'h00};
    repeat (3) step();
    clr_a = '{1'b1, 1'b1};
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset u%0d tx,busy,done,mode,sd", i), 16'({tx_a[i], busy_a[i], done_a[i], mode_a[i], sd_a[i]}), 16'b100_00_0000);
    mon_en = 1'b1;
    send(0, 8'hA5, 0);
    repeat (45) step();
    send(0, 8'h00, 0);
    repeat (40) step();
    e = '{sel: 0, data: 8'hFF, abort: 0};
    sbq.push_back(e);
    data_a[0]  = 8'hFF;
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    repeat (45) step();
    send(0, 8'hC3, 0);
    repeat (14) step();
    data_a[0]  = 8'h11;
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    repeat (45) step();
    send(0, 8'h3C, 22);
    repeat (21) step();
    clr_a[0] = 1'b0;
    step();
    clr_a[0] = 1'b1;
    repeat (5) step();
    send(0, 8'h3C, 0);
    repeat (45) step();
    clr_a[0]   = 1'b0;
    start_a[0] = 1'b1;
    data_a[0]  = 8'h55;
    step();
    clr_a[0]   = 1'b1;
    start_a[0] = 1'b0;
    repeat (6) step();
    send(1, 8'h81, 0);
    repeat (25) step();
    send(1, 8'h6E, 0);
    repeat (25) step();
    chk("scoreboard_empty", 16'(sbq.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_seq.md
UART_TX_SEQ -- requirements
Module: uart_tx_seq

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per UART bit period; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clear_n  input  1  reset, synchronous, active-low.
REQ-004 tx_start  input  1  request to send tx_data; sampled only in IDLE.
REQ-005 tx_data  input  8  byte to transmit; captured in the accept cycle.
REQ-006 sr_q0  input  1  bit 0 of the external 4-bit universal shift register, which updates on falling clk edge.
REQ-007 sr_mode  output  2  shift register command: 00 hold, 01 shift right, 11 parallel load; 10 never driven.
REQ-008 sr_d  output  4  parallel-load nibble for the shift register.
REQ-009 sr_in_rs  output  1  right-shift serial input; constant 0.
REQ-010 sr_in_ls  output  1  left-shift serial input; constant 0.
REQ-011 tx  output  1  registered UART serial line, idle high.
REQ-012 tx_busy  output  1  high while a frame is in progress.
REQ-013 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-015 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); no parity.
REQ-016 Every bit SHALL last CLKS_PER_BIT cycles.
REQ-017 Timing uses a baud counter baud_cnt (0..CLKS_PER_BIT-1) and a bit index bit_idx (0..7).
REQ-018 In IDLE with tx_start=1 (the accept cycle, cycle 0), the block SHALL latch tx_data and enter START at the next edge.
REQ-019 tx SHALL be 0 in cycles 1..N, where N = CLKS_PER_BIT.
REQ-020 Data bit k SHALL appear on tx in cycles 1+N(k+1)..N(k+2).
REQ-021 tx SHALL be 1 (stop bit) in cycles 1+9N..10N.
REQ-022 tx_busy SHALL be 1 in cycles 1..10N and 0 otherwise.
REQ-023 sr_mode SHALL be 11 with sr_d = latched data[3:0] during the first START cycle (cycle 1) only.
REQ-024 Each data bit's tx value SHALL be taken from sr_q0 at the edge entering that bit period; the block SHALL NOT drive tx directly from the latched byte.
REQ-025 During the last cycle of data bits 0, 1, 2, 4, 5 and 6 (baud_cnt = N-1), sr_mode SHALL be 01.
REQ-026 During the last cycle of data bit 3, sr_mode SHALL be 11 with sr_d = latched data[7:4].
REQ-027 During the last cycle of data bit 7, sr_mode SHALL be 00.
REQ-028 In every other cycle, sr_mode SHALL be 00 and sr_d SHALL hold its last value.
REQ-029 tx_done SHALL be 1 for exactly cycle 10N+1, with the state back in IDLE, tx=1 and tx_busy=0.
REQ-030 A tx_start in cycle 10N+1 SHALL be accepted, giving back-to-back frames with no idle gap beyond that cycle.
REQ-031 tx_start while tx_busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-032 Changes on tx_data after the accept cycle SHALL NOT affect the frame in progress.
REQ-033 baud_cnt SHALL wrap from N-1 to 0 at each bit boundary.
REQ-034 bit_idx SHALL advance only at DATA bit boundaries and SHALL reset to 0 on entering START.

Reset
REQ-035 When clear_n=0 at a rising edge, the next-cycle values SHALL be: state IDLE, tx=1, tx_busy=0, tx_done=0, sr_mode=00, sr_d=0000, baud_cnt=0, bit_idx=0, latched data=0.
REQ-036 clear_n=0 SHALL override tx_start in the same cycle.
REQ-037 Reset mid-frame SHALL abort the frame immediately with no tx_done pulse.
REQ-038 After clear_n returns high, the first tx_start SHALL be accepted normally.

Verification
REQ-039 CLKS_PER_BIT=4, tx_start with tx_data=0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; tx_done pulses at cycle 41; sr_mode=11 at cycles 1 and 20, and 01 at cycles 8, 12, 16, 24, 28 and 32.
REQ-040 CLKS_PER_BIT=4, tx_data=0x00, then tx_start=1 again at cycle 41 with tx_data=0xFF -> second frame's start bit in cycles 42..45, then eight 1 bits; tx never glitches high between the two frames' start bits.
REQ-041 tx_start pulsed at cycle 15 of a frame with different tx_data -> ignored; original byte completes unchanged, and exactly one tx_done.
REQ-042 clear_n=0 for one cycle at cycle 22 of an 0x3C frame -> cycle 23 shows tx=1, tx_busy=0, sr_mode=00; no tx_done; a subsequent 0x3C frame transmits correctly.
REQ-043 CLKS_PER_BIT=2, tx_data=0x81 -> tx = 0,1,0,0,0,0,0,0,1,1, each for 2 cycles; tx_done at cycle 21.
REQ-044 Every scenario -> sr_mode never equals 10, and sr_in_rs = sr_in_ls = 0 throughout.
